// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: shares one SPI mode-0 bus between NUM_REQ requesters.
// Requesters are served round-robin. Each transfer sends a 16-bit command word
// followed by a 16-bit data word. The last 16 MISO bits form the read data.
// The block drives SCLK, MOSI and a one-hot active-low chip select. Completion
// is reported on a one-cycle response strobe.
module spi_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_SLAVES = 4,
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYC    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ-1:0]      req_rd_i,
    input  logic [3*NUM_REQ-1:0]    req_cs_i,
    input  logic [8*NUM_REQ-1:0]    req_addr_i,
    input  logic [16*NUM_REQ-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [NUM_REQ-1:0]      rsp_grant_o,
    output logic [15:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    output logic                    sclk_o,
    output logic                    mosi_o,
    input  logic                    miso_i,
    output logic [NUM_SLAVES-1:0]   cs_n_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    state_e         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     owner_q, owner_d;
    logic [2:0]     cs_q, cs_d;
    logic           rd_q, rd_d;
    logic [31:0]    tx_q, tx_d;
    logic [15:0]    rx_q, rx_d;
    logic [15:0]    div_q, div_d;
    logic [4:0]     bit_q, bit_d;
    logic           half_q, half_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]     rsp_grant_q, rsp_grant_d;
    logic [15:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0]  cs_n_q, cs_n_d;

    logic           found_s;
    logic           hit_s;
    logic [2:0]     win_s;
    logic           sel_rd_s;
    logic [2:0]     sel_cs_s;
    logic [7:0]     sel_addr_s;
    logic [15:0]    sel_wdata_s;
    logic           cs_ok_s;
    logic           div_end_s;
    logic           cs_act_s;
    logic [NUM_REQ-1:0] grant_oh_s;

    // Round-robin search starting one slot after the last winner, plus field mux
    always_comb begin
        found_s     = 1'b0;
        hit_s       = 1'b0;
        win_s       = 3'd0;
        sel_rd_s    = 1'b0;
        sel_cs_s    = 3'd0;
        sel_addr_s  = 8'd0;
        sel_wdata_s = 16'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s   = !found_s && req_valid_i[i] && (((int'(ptr_q) + k) % NUM_REQ) == i);
                win_s   = hit_s ? 3'(i) : win_s;
                found_s = found_s | hit_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rd_s    = sel_rd_s    | ((win_s == 3'(i)) & req_rd_i[i]);
            sel_cs_s    = sel_cs_s    | ({3{win_s == 3'(i)}}  & req_cs_i[3*i +: 3]);
            sel_addr_s  = sel_addr_s  | ({8{win_s == 3'(i)}}  & req_addr_i[8*i +: 8]);
            sel_wdata_s = sel_wdata_s | ({16{win_s == 3'(i)}} & req_wdata_i[16*i +: 16]);
        end
        cs_ok_s = (int'(sel_cs_s) < NUM_SLAVES);
    end

    // Acceptance is visible in the same IDLE cycle the fields are captured
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = (state_q == ST_IDLE) && found_s && (win_s == 3'(i));
        end
    end

    assign div_end_s = (div_q == DIV_LAST);

    // State register and transfer datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'(NUM_REQ - 1);
            owner_q <= 3'd0;
            cs_q    <= 3'd0;
            rd_q    <= 1'b0;
            tx_q    <= 32'd0;
            rx_q    <= 16'd0;
            div_q   <= 16'd0;
            bit_q   <= 5'd0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
        end
    end

    // Next-state logic: phase timing, bit counting, shift registers
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cs_d    = cs_q;
        rd_d    = rd_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        div_d   = div_q;
        bit_d   = bit_q;
        half_d  = half_q;
        case (state_q)
            ST_IDLE: begin
                div_d = 16'd0;
                if (found_s) begin
                    ptr_d   = win_s;
                    owner_d = win_s;
                    cs_d    = sel_cs_s;
                    rd_d    = sel_rd_s;
                    tx_d    = {5'b00000, sel_addr_s, 1'b0, sel_rd_s, 1'b0,
                               (sel_rd_s ? 16'h0000 : sel_wdata_s)};
                    state_d = cs_ok_s ? ST_SETUP : ST_ERR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (div_end_s) begin
                    div_d   = 16'd0;
                    bit_d   = 5'd0;
                    half_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (div_end_s) begin
                    div_d = 16'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (bit_q == 5'd31) begin
                        half_d  = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        half_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                        tx_d   = {tx_q[30:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
                // MISO is taken in the first cycle of each high half
                if (half_q && (div_q == 16'd0)) begin
                    rx_d = {rx_q[14:0], miso_i};
                end else begin
                    rx_d = rx_q;
                end
            end
            ST_HOLD: begin
                if (div_end_s) begin
                    div_d   = 16'd0;
                    state_d = ST_GAP;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = 16'd0;
                    state_d = ST_DONE;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every pin comes straight from a flop
    always_comb begin
        cs_act_s = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
        sclk_d   = (state_d == ST_SHIFT) && half_d;
        mosi_d   = cs_act_s ? tx_d[31] : 1'b0;
        busy_d   = (state_d != ST_IDLE);
        for (int s = 0; s < NUM_SLAVES; s++) begin
            cs_n_d[s] = ~(cs_act_s && (cs_d == 3'(s)));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh_s[i] = (owner_d == 3'(i));
        end
        rsp_valid_d = (state_d == ST_ERR) || (state_d == ST_DONE);
        if (state_d == ST_ERR) begin
            rsp_grant_d = grant_oh_s;
            rsp_rdata_d = 16'h0000;
            rsp_err_d   = 1'b1;
        end else if (state_d == ST_DONE) begin
            rsp_grant_d = grant_oh_s;
            rsp_rdata_d = rd_q ? rx_q : 16'h0000;
            rsp_err_d   = 1'b0;
        end else begin
            rsp_grant_d = rsp_grant_q;
            rsp_rdata_d = rsp_rdata_q;
            rsp_err_d   = rsp_err_q;
        end
    end

    // Output registers; reset drops the bus to idle immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_grant_q <= '0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= '1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_grant_q <= rsp_grant_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_grant_o = rsp_grant_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;
    assign cs_n_o      = cs_n_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: a behavioural SPI RAM slave on
// instance A (CLK_DIV=8) and a latency-only instance B (CLK_DIV=4).
module tb_spi_master_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic [1:0]  req_valid_a = 2'b00;
    logic [1:0]  req_ready_a;
    logic [1:0]  req_rd_a    = 2'b00;
    logic [5:0]  req_cs_a    = 6'd0;
    logic [15:0] req_addr_a  = 16'd0;
    logic [31:0] req_wdata_a = 32'd0;
    logic        rsp_valid_a, rsp_err_a, busy_a, sclk_a, mosi_a;
    logic [1:0]  rsp_grant_a;
    logic [15:0] rsp_rdata_a;
    logic        miso_a = 1'b0;
    logic [3:0]  cs_n_a;

    spi_master_arbiter #(.NUM_REQ(2), .NUM_SLAVES(4), .CLK_DIV(8), .GAP_CYC(8)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_rd_i(req_rd_a),
        .req_cs_i(req_cs_a), .req_addr_i(req_addr_a), .req_wdata_i(req_wdata_a),
        .rsp_valid_o(rsp_valid_a), .rsp_grant_o(rsp_grant_a), .rsp_rdata_o(rsp_rdata_a),
        .rsp_err_o(rsp_err_a), .busy_o(busy_a), .sclk_o(sclk_a), .mosi_o(mosi_a),
        .miso_i(miso_a), .cs_n_o(cs_n_a)
    );

    // ---------------- instance B ----------------
    logic [1:0]  req_valid_b = 2'b00;
    logic [1:0]  req_ready_b;
    logic [1:0]  req_rd_b    = 2'b00;
    logic [5:0]  req_cs_b    = 6'd0;
    logic [15:0] req_addr_b  = 16'h0003;
    logic [31:0] req_wdata_b = 32'h0000A5A5;
    logic        rsp_valid_b, rsp_err_b, busy_b, sclk_b, mosi_b;
    logic [1:0]  rsp_grant_b;
    logic [15:0] rsp_rdata_b;
    logic        miso_b = 1'b0;
    logic [3:0]  cs_n_b;

    spi_master_arbiter #(.NUM_REQ(2), .NUM_SLAVES(4), .CLK_DIV(4), .GAP_CYC(8)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_rd_i(req_rd_b),
        .req_cs_i(req_cs_b), .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b),
        .rsp_valid_o(rsp_valid_b), .rsp_grant_o(rsp_grant_b), .rsp_rdata_o(rsp_rdata_b),
        .rsp_err_o(rsp_err_b), .busy_o(busy_b), .sclk_o(sclk_b), .mosi_o(mosi_b),
        .miso_i(miso_b), .cs_n_o(cs_n_b)
    );

    // ---------------- slave model for A ----------------
    logic [15:0] mem [4][256];
    logic        mem_clr = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [31:0] shin = 32'd0;
    int          bitn = 0;
    logic        rdflag = 1'b0;
    logic [15:0] rdword = 16'd0;
    int          rises_a = 0;

    function automatic int slave_sel(input logic [3:0] c);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) if (!c[k]) s = k;
        return s;
    endfunction

    // RAM slave: command then data, MSB first, reply driven after falling edges
    always @(posedge clk) begin
        sclk_prev <= sclk_a;
        if (mem_clr) begin
            for (int s = 0; s < 4; s++)
                for (int a = 0; a < 256; a++) mem[s][a] <= 16'h0000;
        end
        if (&cs_n_a) begin
            bitn   <= 0;
            miso_a <= 1'b0;
            rdflag <= 1'b0;
        end else if (sclk_a && !sclk_prev) begin
            rises_a <= rises_a + 1;
            shin    <= {shin[30:0], mosi_a};
            bitn    <= bitn + 1;
            if (bitn == 15) begin
                rdflag <= shin[0];
                rdword <= mem[slave_sel(cs_n_a)][shin[9:2]];
            end
            if (bitn == 31 && !rdflag)
                mem[slave_sel(cs_n_a)][shin[25:18]] <= {shin[14:0], mosi_a};
        end else if (!sclk_a && sclk_prev) begin
            if (rdflag && bitn >= 16 && bitn < 32) miso_a <= rdword[31 - bitn];
        end
    end

    // Bus monitors: response strobes, chip-select sanity, SCLK rises on B
    int rsp_cnt_a = 0;
    int bad_cs_a  = 0;
    int rises_b   = 0;
    logic sclk_b_prev = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid_a) rsp_cnt_a <= rsp_cnt_a + 1;
        if (cs_n_a != 4'hF && $countones(~cs_n_a) != 1) bad_cs_a <= bad_cs_a + 1;
        sclk_b_prev <= sclk_b;
        if (sclk_b && !sclk_b_prev) rises_b <= rises_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req_a(input int r, input logic rd, input logic [2:0] cs,
                            input logic [7:0] addr, input logic [15:0] wd, output int t);
        bit seen;
        seen = 1'b0;
        t = 0;
        req_rd_a[r] = rd;
        req_cs_a[3*r +: 3] = cs;
        req_addr_a[8*r +: 8] = addr;
        req_wdata_a[16*r +: 16] = wd;
        req_valid_a[r] = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready_a[r]) begin
                seen = 1'b1;
                t = cyc;
                break;
            end
        end
        chk("ready_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a[r] = 1'b0;
    endtask

    task automatic wait_rsp_a(input int budget, output int t);
        bit seen;
        seen = 1'b0;
        t = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid_a) begin
                seen = 1'b1;
                t = cyc;
                break;
            end
        end
        chk("rsp_seen", {31'd0, seen}, 32'd1);
    endtask

    int t_rdy, t_rsp, r0, c0, b0;
    bit seen_b;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready",  {30'd0, req_ready_a}, 32'd0);
        chk("rst_rvalid", {31'd0, rsp_valid_a}, 32'd0);
        chk("rst_grant",  {30'd0, rsp_grant_a}, 32'd0);
        chk("rst_rdata",  {16'd0, rsp_rdata_a}, 32'd0);
        chk("rst_err",    {31'd0, rsp_err_a},   32'd0);
        chk("rst_busy",   {31'd0, busy_a},      32'd0);
        chk("rst_sclk",   {31'd0, sclk_a},      32'd0);
        chk("rst_mosi",   {31'd0, mosi_a},      32'd0);
        chk("rst_cs_n",   {28'd0, cs_n_a},      32'h0000000F);
        rst = 1'b0;
        mem_clr = 1'b0;
        @(posedge clk);
        #1;

        // Write slave 1 addr 0x2A = 0xBEEF, latency and edge count at CLK_DIV=8
        r0 = rises_a;
        do_req_a(0, 1'b0, 3'd1, 8'h2A, 16'hBEEF, t_rdy);
        @(negedge clk);
        chk("wr_cs_n_T1", {28'd0, cs_n_a}, 32'h0000000D);
        wait_rsp_a(2000, t_rsp);
        chk("wr_latency8", t_rsp - t_rdy, 32'd537);
        chk("wr_grant",    {30'd0, rsp_grant_a}, 32'd1);
        chk("wr_err",      {31'd0, rsp_err_a},   32'd0);
        chk("wr_rdata",    {16'd0, rsp_rdata_a}, 32'd0);
        chk("wr_rises",    rises_a - r0, 32'd32);

        // Read it back through requester 1
        do_req_a(1, 1'b1, 3'd1, 8'h2A, 16'h0000, t_rdy);
        wait_rsp_a(2000, t_rsp);
        chk("rd_rdata",   {16'd0, rsp_rdata_a}, 32'h0000BEEF);
        chk("rd_err",     {31'd0, rsp_err_a},   32'd0);
        chk("rd_grant",   {30'd0, rsp_grant_a}, 32'd2);
        chk("rd_latency", t_rsp - t_rdy, 32'd537);

        // Read of an unwritten address, single chip select active
        b0 = bad_cs_a;
        do_req_a(0, 1'b1, 3'd2, 8'h55, 16'h0000, t_rdy);
        @(negedge clk);
        chk("unw_cs_n_T1", {28'd0, cs_n_a}, 32'h0000000B);
        wait_rsp_a(2000, t_rsp);
        chk("unw_rdata",  {16'd0, rsp_rdata_a}, 32'd0);
        chk("unw_one_cs", bad_cs_a - b0, 32'd0);

        // Out-of-range chip select
        r0 = rises_a;
        do_req_a(0, 1'b0, 3'd5, 8'h11, 16'h1234, t_rdy);
        @(negedge clk);
        chk("err_rvalid_T1", {31'd0, rsp_valid_a}, 32'd1);
        chk("err_flag",      {31'd0, rsp_err_a},   32'd1);
        chk("err_rdata",     {16'd0, rsp_rdata_a}, 32'd0);
        chk("err_grant",     {30'd0, rsp_grant_a}, 32'd1);
        chk("err_cs_n",      {28'd0, cs_n_a},      32'h0000000F);
        repeat (4) @(negedge clk);
        chk("err_rises",     rises_a - r0, 32'd0);
        @(posedge clk);
        #1;

        // Both requesters continuously valid: owner of last grant was 0
        req_rd_a    = 2'b00;
        req_cs_a    = {3'd3, 3'd0};
        req_addr_a  = {8'h02, 8'h01};
        req_wdata_a = {16'h2222, 16'h1111};
        req_valid_a = 2'b11;
        wait_rsp_a(2000, t_rsp);
        chk("rr_grant0", {30'd0, rsp_grant_a}, 32'd2);
        wait_rsp_a(2000, t_rsp);
        chk("rr_grant1", {30'd0, rsp_grant_a}, 32'd1);
        wait_rsp_a(2000, t_rsp);
        chk("rr_grant2", {30'd0, rsp_grant_a}, 32'd2);
        wait_rsp_a(2000, t_rsp);
        chk("rr_grant3", {30'd0, rsp_grant_a}, 32'd1);
        req_valid_a = 2'b00;
        @(posedge clk);
        #1;
        do_req_a(0, 1'b1, 3'd3, 8'h02, 16'h0000, t_rdy);
        wait_rsp_a(2000, t_rsp);
        chk("rr_readback", {16'd0, rsp_rdata_a}, 32'h00002222);

        // Reset in the middle of a transfer
        do_req_a(0, 1'b0, 3'd0, 8'h10, 16'h1234, t_rdy);
        r0 = rises_a;
        c0 = rsp_cnt_a;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rises_a - r0 >= 10) break;
        end
        chk("mid_rises10", rises_a - r0, 32'd10);
        rst = 1'b1;
        #1;
        chk("mid_cs_n", {28'd0, cs_n_a}, 32'h0000000F);
        chk("mid_sclk", {31'd0, sclk_a}, 32'd0);
        chk("mid_busy", {31'd0, busy_a}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("mid_no_rsp", rsp_cnt_a - c0, 32'd0);
        @(posedge clk);
        #1;
        do_req_a(0, 1'b0, 3'd0, 8'h10, 16'h1234, t_rdy);
        wait_rsp_a(2000, t_rsp);
        chk("post_wr_grant", {30'd0, rsp_grant_a}, 32'd1);
        do_req_a(1, 1'b1, 3'd0, 8'h10, 16'h0000, t_rdy);
        wait_rsp_a(2000, t_rsp);
        chk("post_rd_rdata", {16'd0, rsp_rdata_a}, 32'h00001234);
        chk("post_rd_grant", {30'd0, rsp_grant_a}, 32'd2);

        // Instance B: CLK_DIV=4 latency and edge count
        @(posedge clk);
        #1;
        r0 = rises_b;
        seen_b = 1'b0;
        req_valid_b = 2'b01;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready_b[0]) begin
                seen_b = 1'b1;
                t_rdy = cyc;
                break;
            end
        end
        chk("b_ready_seen", {31'd0, seen_b}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_b = 2'b00;
        @(negedge clk);
        chk("b_cs_n_T1", {28'd0, cs_n_b}, 32'h0000000E);
        seen_b = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rsp_valid_b) begin
                seen_b = 1'b1;
                t_rsp = cyc;
                break;
            end
        end
        chk("b_rsp_seen",  {31'd0, seen_b}, 32'd1);
        chk("b_latency4",  t_rsp - t_rdy, 32'd273);
        chk("b_rises",     rises_b - r0, 32'd32);
        chk("b_grant",     {30'd0, rsp_grant_b}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
